// File: rtl/seq_display_player.sv
// Steps through a writable table of BCD patterns and drives NDIG seven-segment digits.
// The index advances on prescaled ticks, in one of four modes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_PAUSE | idle, prescaler held at 0, index frozen
// ST_RUN   | prescaler counting, index moves on each tick
// ST_DONE  | one-shot reached the last entry, waits for run=0
module seq_display_player #(
  parameter int NDIG     = 3,
  parameter int DEPTH    = 24,
  parameter int DIV_BITS = 25,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [1:0]          mode,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [4*NDIG-1:0]   wr_data,
  output logic [AW-1:0]       step_idx,
  output logic                done,
  output logic [7*NDIG-1:0]   seg7,
  output logic [NDIG-1:0]     seg7_dpt
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       idx_inc, idx_dec, pp_next;
  logic                dir_up_q, dir_up_d;
  logic                tick;
  logic                addr_ok;
  logic [4*NDIG-1:0]   pattern [DEPTH];
  logic [4*NDIG-1:0]   cur_pat;
  logic [7*NDIG-1:0]   seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign tick    = (state_q == ST_RUN) && (&presc_q);
  assign idx_inc = idx_q + 1'b1;
  assign idx_dec = idx_q - 1'b1;

  // Ping-pong: turn around at either end so each endpoint is shown once per pass.
  always_comb begin
    pp_next = idx_inc;
    if (dir_up_q) begin
      if (idx_q == LAST) pp_next = idx_dec;
    end else if (idx_q != '0) begin
      pp_next = idx_dec;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_up_d = dir_up_q;
    presc_d  = '0;
    case (state_q)
      ST_PAUSE: begin
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d = presc_q + 1'b1;
        if (!run) state_d = ST_PAUSE;
        if (tick) begin
          case (mode)
            2'b00: idx_d = (idx_q == LAST) ? '0 : idx_inc;
            2'b01: idx_d = (idx_q == '0) ? LAST : idx_dec;
            2'b10: begin
              idx_d = pp_next;
              if (pp_next == LAST)    dir_up_d = 1'b0;
              else if (pp_next == '0) dir_up_d = 1'b1;
              else                    dir_up_d = (pp_next > idx_q);
            end
            default: begin
              // Already at the end (mode switched late): finish without moving.
              if (idx_q == LAST) begin
                state_d = ST_DONE;
              end else begin
                idx_d = idx_inc;
                if (idx_inc == LAST) state_d = ST_DONE;
              end
            end
          endcase
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_d = ST_PAUSE;
          idx_d   = '0;
        end
      end
      default: state_d = ST_PAUSE;
    endcase
    if (mode != 2'b10) dir_up_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_PAUSE;
      presc_q  <= '0;
      idx_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      dir_up_q <= dir_up_d;
    end
  end

  generate
    if (DEPTH == (1 << AW)) begin : g_full_addr
      assign addr_ok = 1'b1;
    end else begin : g_part_addr
      assign addr_ok = (32'(wr_addr) < 32'(DEPTH));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else if (wr_en && addr_ok) begin
      pattern[wr_addr] <= wr_data;
    end
  end

  assign cur_pat = pattern[idx_q];

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < NDIG; k++) seg_d[7*k +: 7] = seg_decode(cur_pat[4*k +: 4]);
  end

  // Display follows the registered index and table contents one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg7     <= {NDIG{7'h3F}};
      seg7_dpt <= '0;
    end else begin
      seg7     <= seg_d;
      seg7_dpt <= NDIG'(state_q == ST_DONE);
    end
  end

  assign step_idx = idx_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_display_player.sv
// Directed and randomized bench for seq_display_player (NDIG=2, DEPTH=4, DIV_BITS=2)
// against a cycle-level reference model built from the stepping rules.
module tb_seq_display_player;
  localparam int NDIG   = 2;
  localparam int DEPTH  = 4;
  localparam int DIVB   = 2;
  localparam int PERIOD = 1 << DIVB;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [1:0]  mode;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  step_idx;
  logic        done;
  logic [13:0] seg7;
  logic [1:0]  seg7_dpt;

  seq_display_player #(.NDIG(NDIG), .DEPTH(DEPTH), .DIV_BITS(DIVB)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_idx(step_idx), .done(done), .seg7(seg7), .seg7_dpt(seg7_dpt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Reference model: 0 = paused, 1 = running, 2 = done
  int          m_st, m_cnt, m_idx, m_up;
  logic [7:0]  m_pat [DEPTH];
  logic [13:0] m_seg;
  logic [1:0]  m_dpt;

  function automatic logic [13:0] exp_seg(input logic [7:0] p);
    return {seg_tab[p[7:4]], seg_tab[p[3:0]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_idx = 0; m_up = 1;
    for (int i = 0; i < DEPTH; i++) m_pat[i] = 8'h00;
    m_seg = 14'h1FBF;
    m_dpt = 2'b00;
  endtask

  task automatic model_edge();
    int  nidx, nst;
    bit  tk;
    m_seg = exp_seg(m_pat[m_idx]);
    m_dpt = {1'b0, m_st == 2};
    tk    = (m_st == 1) && (m_cnt == PERIOD - 1);
    nidx  = m_idx;
    nst   = m_st;
    case (m_st)
      0: if (run) nst = 1;
      1: begin
        if (!run) nst = 0;
        if (tk) begin
          case (mode)
            2'd0: nidx = (m_idx + 1) % DEPTH;
            2'd1: nidx = (m_idx + DEPTH - 1) % DEPTH;
            2'd2: begin
              if (m_up != 0) begin
                if (m_idx == DEPTH - 1) begin m_up = 0; nidx = m_idx - 1; end
                else nidx = m_idx + 1;
              end else begin
                if (m_idx == 0) begin m_up = 1; nidx = 1; end
                else nidx = m_idx - 1;
              end
              if (nidx == DEPTH - 1) m_up = 0;
              if (nidx == 0) m_up = 1;
            end
            default: begin
              if (m_idx < DEPTH - 1) nidx = m_idx + 1;
              if (nidx == DEPTH - 1) nst = 2;
            end
          endcase
        end
      end
      default: if (!run) begin nst = 0; nidx = 0; end
    endcase
    m_cnt = (m_st == 1) ? (m_cnt + 1) % PERIOD : 0;
    if (mode != 2'd2) m_up = 1;
    if (wr_en) m_pat[wr_addr] = wr_data;
    m_idx = nidx;
    m_st  = nst;
  endtask

  task automatic compare_all();
    chk("step_idx", 32'(step_idx), 32'(m_idx));
    chk("done",     32'(done),     32'(m_st == 2));
    chk("seg7",     32'(seg7),     32'(m_seg));
    chk("seg7_dpt", 32'(seg7_dpt), 32'(m_dpt));
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  logic [7:0]  pats    [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  int          up_idx  [4] = '{1, 2, 3, 0};
  logic [13:0] up_seg  [4] = '{{7'h4F, 7'h66}, {7'h6D, 7'h7D}, {7'h07, 7'h7F}, {7'h06, 7'h5B}};
  int          pp_idx  [7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    rst = 1'b0; run = 1'b0; mode = 2'd0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    model_reset();
    #12;
    chk("reset_idx",  32'(step_idx), 32'd0);
    chk("reset_seg7", 32'(seg7),     32'h1FBF);
    chk("reset_done", 32'(done),     32'd0);
    chk("reset_dpt",  32'(seg7_dpt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    cycle(20);
    chk("idle_idx",  32'(step_idx), 32'd0);
    chk("idle_seg7", 32'(seg7),     32'h1FBF);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = pats[i];
      cycle(1);
    end
    wr_en = 1'b0;

    // loop-up
    mode = 2'd0; run = 1'b1;
    cycle(5);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("up_idx%0d", s), 32'(step_idx), 32'(up_idx[s]));
      cycle(1);
      chk($sformatf("up_seg%0d", s), 32'(seg7), 32'(up_seg[s]));
      if (s < 3) cycle(3);
    end
    run = 1'b0;
    cycle(2);

    // ping-pong
    mode = 2'd2; run = 1'b1;
    cycle(5);
    chk("pp_idx0", 32'(step_idx), 32'(pp_idx[0]));
    for (int s = 1; s < 7; s++) begin
      cycle(4);
      chk($sformatf("pp_idx%0d", s), 32'(step_idx), 32'(pp_idx[s]));
    end

    // one-shot
    mode = 2'd3;
    cycle(4);
    chk("os_idx2",  32'(step_idx), 32'd2);
    chk("os_busy",  32'(done),     32'd0);
    cycle(4);
    chk("os_idx3",  32'(step_idx), 32'd3);
    chk("os_done",  32'(done),     32'd1);
    cycle(1);
    chk("os_dpt",   32'(seg7_dpt), 32'd1);
    cycle(8);
    chk("os_frozen", 32'(step_idx), 32'd3);
    run = 1'b0;
    cycle(1);
    chk("os_clr_idx",  32'(step_idx), 32'd0);
    chk("os_clr_done", 32'(done),     32'd0);

    // loop-down and blanking write
    mode = 2'd1; run = 1'b1;
    cycle(5);
    chk("dn_idx3", 32'(step_idx), 32'd3);
    cycle(4);
    chk("dn_idx2", 32'(step_idx), 32'd2);
    cycle(4);
    chk("dn_idx1", 32'(step_idx), 32'd1);
    cycle(4);
    chk("dn_idx0", 32'(step_idx), 32'd0);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    cycle(1);
    wr_en = 1'b0;
    chk("blank_pre",  32'(seg7), 32'({7'h06, 7'h5B}));
    cycle(1);
    chk("blank_post", 32'(seg7), 32'd0);
    cycle(2);
    chk("dn_wrap", 32'(step_idx), 32'd3);
    cycle(2);

    // reset two cycles before a tick
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_idx",  32'(step_idx), 32'd0);
    chk("mid_rst_seg7", 32'(seg7),     32'h1FBF);
    chk("mid_rst_done", 32'(done),     32'd0);
    compare_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_held_idx", 32'(step_idx), 32'd0);
    rst = 1'b1;
    cycle(4);
    chk("no_early_tick", 32'(step_idx), 32'd0);
    cycle(1);
    chk("first_tick", 32'(step_idx), 32'd3);

    // randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      run     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      if (it == 300) begin
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk); #1;
        rst = 1'b1;
      end
      cycle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
